cosine_controller: RTL and testbench
====================================

# cosine_controller

Sequencing FSM that sits directly upstream of the cosine datapath. It drives the datapath's 3-bit `state` bus through the standby, start, series-accumulation and distance phases, and counts Taylor terms. It waits for the datapath `done` flag, registers the Q5.11 `distance` result, and raises an alarm when the result falls below a programmable threshold.

## Interface
Parameters:
- `N_TERMS`, default 6: number of AccumulateTerms cycles per measurement; legal range 1..15.
- `THRESHOLD`, default 16'h0800: signed Q5.11 alarm threshold (1.0).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: measurement request; sampled only in STANDBY.
- `ack` in 1: alarm acknowledge; sampled only in ALERT.
- `done` in 1: datapath completion flag.
- `distance` in 16: datapath result, signed Q5.11.
- `state` out 3: phase code to the datapath.
- `busy` out 1: high in every state except STANDBY and ALERT.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `result` out 16: last captured distance.
- `alarm` out 1: high while in ALERT.

## Operation
State encoding:
- STANDBY=0, ALERT=1, START_CALC=2, ACCUMULATE=3, CALC_DIST=4, CHECK=5.
- Codes 6 and 7 are illegal and recover to STANDBY on the next edge.
- The datapath treats code 5 as idle.

Transitions:
- STANDBY: `start`=1 -> START_CALC; otherwise stay.
- START_CALC: lasts one cycle -> ACCUMULATE; the term counter is cleared to 0.
- ACCUMULATE: the term counter increments each cycle. When counter == N_TERMS-1 -> CALC_DIST. Exactly N_TERMS cycles are spent here.
- CALC_DIST: lasts one cycle -> CHECK.
- CHECK with `done`=0: stay (no timeout).
- CHECK with `done`=1: capture `distance` into `result` and pulse `result_valid` next cycle. If $signed(distance) < $signed(THRESHOLD) -> ALERT, else -> STANDBY.
- ALERT: `alarm`=1 until `ack`=1 -> STANDBY.

Input and boundary rules:
- `start` is ignored in every state except STANDBY; it is never queued.
- `ack` is ignored outside ALERT.
- `start` and `ack` both high in ALERT: go to STANDBY; `start` is dropped.
- distance == THRESHOLD: no alarm (the compare is strict).
- `done` is only examined in CHECK. The datapath's done register is cleared during START_CALC, so a stale `done` cannot end a new measurement early.

## Timing
- Reset values: `state`=STANDBY, `result`=0, `result_valid`=0, `alarm`=0, `busy`=0, counter=0.
- `rst` in any state, including mid-ACCUMULATE or ALERT, returns to these values on the next edge. `rst` has priority over all other inputs.
- All outputs are registered or decoded from the state register; there is no combinational input-to-output path.
- Latency with `start` sampled in cycle 0:
  - START_CALC in cycle 1.
  - ACCUMULATE in cycles 2..N_TERMS+1.
  - CALC_DIST in cycle N_TERMS+2.
  - CHECK in cycle N_TERMS+3.
  - `result_valid`=1 in cycle N_TERMS+4 (10 for the default), if `done` was high in CHECK.
- `alarm` rises in the same cycle as `result_valid`.
- Back-to-back operation: the earliest next `start` is sampled in the cycle where `result_valid` is high (state already STANDBY).

## Structure
- Shared package `cosine_pkg`:
  - the six state-code constants, also used by the datapath;
  - the Q5.11 ONE constant (16'h0800);
  - Q5.11 width constants (5 integer bits, 11 fraction bits).
- Sub-module `term_counter`: 4-bit counter with synchronous clear, increment enable and terminal-count output (count == N_TERMS-1).
- The FSM and output registers live in the top.

## Test plan
- Reset then `start` pulse in cycle 0, `done` tied high, distance=16'h1000 -> `state` sequence 0,2,3×6,4,5,0; `result_valid` in cycle 10, `result`=16'h1000, `alarm`=0.
- distance=16'hFC00 (-0.5) -> ALERT in cycle 10, `alarm` held over 20 idle cycles. `ack` -> STANDBY next cycle; `result` still 16'hFC00.
- distance=16'h0800 (equal to threshold) -> no alarm. distance=16'h07FF -> alarm.
- `done` held low for 5 cycles in CHECK -> state stays 5, `busy`=1; `done` rises -> `result_valid` the following cycle.
- Noise on `start` during ACCUMULATE and `ack` during STANDBY -> no effect. `start`+`ack` together in ALERT -> STANDBY, and no new measurement starts.
- `rst` asserted at the 3rd ACCUMULATE cycle -> all outputs at reset values next cycle. A new `start` then yields a full N_TERMS-cycle sequence.

Source files
------------

// File: rtl/cosine_pkg.sv
// Shared definitions for the cosine controller and its datapath.
// Phase codes and Q5.11 fixed-point constants.
package cosine_pkg;

  localparam int Q_INT  = 5;
  localparam int Q_FRAC = 11;
  localparam int Q_W    = Q_INT + Q_FRAC;

  localparam logic [Q_W-1:0] Q_ONE = 16'h0800;

  typedef enum logic [2:0] {
    ST_STANDBY    = 3'd0,
    ST_ALERT      = 3'd1,
    ST_START_CALC = 3'd2,
    ST_ACCUMULATE = 3'd3,
    ST_CALC_DIST  = 3'd4,
    ST_CHECK      = 3'd5
  } state_e;

endpackage

// File: rtl/term_counter.sv
// Taylor term counter: sync clear, increment enable,
// terminal count at N_TERMS-1.
module term_counter #(
  parameter int N_TERMS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [3:0] LAST = 4'(N_TERMS - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/cosine_controller.sv
// Sequencing FSM for the cosine datapath: runs the term
// series, waits for done, captures distance, raises alarm.
module cosine_controller
  import cosine_pkg::*;
#(
  parameter int         N_TERMS   = 6,
  parameter logic [15:0] THRESHOLD = Q_ONE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic        done,
  input  logic [15:0] distance,
  output logic [2:0]  state,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] result,
  output logic        alarm
);

  state_e      state_q, state_d;
  logic [15:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        cnt_clr, cnt_inc, cnt_tc;
  logic        below;

  term_counter #(
    .N_TERMS (N_TERMS)
  ) u_term_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  // Strict compare: a result equal to the threshold is healthy.
  assign below = $signed(distance) < $signed(THRESHOLD);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_STANDBY: begin
        if (start)
          state_d = ST_START_CALC;
      end
      ST_START_CALC: begin
        cnt_clr = 1'b1;
        state_d = ST_ACCUMULATE;
      end
      ST_ACCUMULATE: begin
        cnt_inc = 1'b1;
        if (cnt_tc)
          state_d = ST_CALC_DIST;
      end
      ST_CALC_DIST: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (done) begin
          result_d = distance;
          valid_d  = 1'b1;
          state_d  = below ? ST_ALERT : ST_STANDBY;
        end
      end
      ST_ALERT: begin
        if (ack)
          state_d = ST_STANDBY;
      end
      default: begin
        state_d = ST_STANDBY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_STANDBY;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign state        = state_q;
  assign busy         = (state_q != ST_STANDBY) &&
                        (state_q != ST_ALERT);
  assign alarm        = (state_q == ST_ALERT);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_cosine_controller.sv
// Self-checking bench for cosine_controller: vector table,
// result scoreboard and hand-written corner sequences.
module tb_cosine_controller;
  import cosine_pkg::*;

  localparam int NT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ack;
  logic        done;
  logic [15:0] distance;
  logic [2:0]  state;
  logic        busy;
  logic        result_valid;
  logic [15:0] result;
  logic        alarm;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        alm;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic        alm;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  cosine_controller #(
    .N_TERMS   (NT),
    .THRESHOLD (16'h0800)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ack          (ack),
    .done         (done),
    .distance     (distance),
    .state        (state),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .alarm        (alarm)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every captured result is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && result_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        chk("sb_result", 32'(result), 32'(e.res));
        chk("sb_alarm", 32'(alarm), 32'(e.alm));
      end
    end
  end

  // Start a measurement in STANDBY, walk to the CHECK cycle.
  task automatic run_to_check(input logic [15:0] d,
                              input logic exp_alm,
                              input logic noise);
    distance = d;
    start    = 1'b1;
    sbq.push_back(exp_t'{res: d, alm: exp_alm});
    step();
    start = 1'b0;
    chk("start_calc", 32'(state), 32'd2);
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < NT; i++) begin
      start = noise;
      step();
      chk("accumulate", 32'(state), 32'd3);
    end
    start = 1'b0;
    step();
    chk("calc_dist", 32'(state), 32'd4);
    step();
    chk("check", 32'(state), 32'd5);
    chk("busy_check", 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{d: 16'h1000, alm: 1'b0};
    vecs[1] = '{d: 16'hFC00, alm: 1'b1};
    vecs[2] = '{d: 16'h0800, alm: 1'b0};
    vecs[3] = '{d: 16'h07FF, alm: 1'b1};
    vecs[4] = '{d: 16'h8000, alm: 1'b1};
    vecs[5] = '{d: 16'h7FFF, alm: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    ack      = 1'b0;
    done     = 1'b1;
    distance = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_to_check(vecs[i].d, vecs[i].alm, 1'b0);
      step();
      chk("vec_valid", 32'(result_valid), 32'd1);
      chk("vec_result", 32'(result), 32'(vecs[i].d));
      chk("vec_alarm", 32'(alarm), 32'(vecs[i].alm));
      chk("vec_state", 32'(state), vecs[i].alm ? 32'd1 : 32'd0);
      chk("vec_busy", 32'(busy), 32'd0);
      if (vecs[i].alm) begin
        for (int k = 0; k < 20; k++) begin
          step();
          chk("alarm_hold", 32'(alarm), 32'd1);
        end
        chk("alert_state", 32'(state), 32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_state", 32'(state), 32'd0);
        chk("ack_alarm", 32'(alarm), 32'd0);
        chk("ack_result", 32'(result), 32'(vecs[i].d));
        chk("ack_valid", 32'(result_valid), 32'd0);
      end
    end

    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ack_idle_state", 32'(state), 32'd0);
      chk("ack_idle_busy", 32'(busy), 32'd0);
    end
    ack = 1'b0;

    done = 1'b0;
    run_to_check(16'h0C00, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wait_state", 32'(state), 32'd5);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_valid", 32'(result_valid), 32'd0);
    end
    done = 1'b1;
    step();
    chk("late_valid", 32'(result_valid), 32'd1);
    chk("late_result", 32'(result), 32'h0C00);
    chk("late_state", 32'(state), 32'd0);
    step();
    chk("no_queue_state", 32'(state), 32'd0);
    chk("no_queue_valid", 32'(result_valid), 32'd0);

    run_to_check(16'hFC00, 1'b1, 1'b0);
    step();
    chk("sa_alert", 32'(state), 32'd1);
    start = 1'b1;
    ack   = 1'b1;
    step();
    start = 1'b0;
    ack   = 1'b0;
    chk("sa_state", 32'(state), 32'd0);
    chk("sa_alarm", 32'(alarm), 32'd0);
    step();
    chk("sa_no_start", 32'(state), 32'd0);
    chk("sa_busy", 32'(busy), 32'd0);

    distance = 16'h1000;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("acc3_state", 32'(state), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_alarm", 32'(alarm), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);

    run_to_check(16'h0400, 1'b1, 1'b0);
    step();
    chk("post_rst_valid", 32'(result_valid), 32'd1);
    chk("post_rst_result", 32'(result), 32'h0400);
    chk("post_rst_alarm", 32'(alarm), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("post_rst_ack", 32'(state), 32'd0);

    step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
